// File: rtl/axis_extremum_finder_pkg.sv
// axis_extremum_finder_pkg: shared state type and default sizing for the extremum finder.
package axis_extremum_finder_pkg;
    localparam int DEF_CHANNEL_COUNT   = 2;
    localparam int DEF_CHANNEL_WIDTH   = 16;
    localparam int DEF_LOG_COUNT_WIDTH = 5;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} ef_state_t;
endpackage

// File: rtl/axis_extremum_channel.sv
// axis_extremum_channel: per-channel running signed max/min with shifted result of the current sample.
module axis_extremum_channel #(
    parameter int W = 16
) (
    input  logic                aclk_i,
    input  logic                areset_i,
    input  logic signed [W-1:0] sample_i,
    input  logic                valid_i,
    input  logic                first_i,
    input  logic [2:0]          shift_i,
    output logic signed [W-1:0] max_o,
    output logic signed [W-1:0] min_o
);
    logic signed [W-1:0] max_q, max_d, min_q, min_d;
    // The first sample reloads both extrema so stale values never leak between windows.
    always_comb begin
        max_d = (first_i || sample_i > max_q) ? sample_i : max_q;
        min_d = (first_i || sample_i < min_q) ? sample_i : min_q;
    end
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            max_q <= '0;
            min_q <= '0;
        end else if (valid_i) begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end
    assign max_o = max_d >>> shift_i;
    assign min_o = min_d >>> shift_i;
endmodule

// File: rtl/axis_extremum_finder_mc.sv
// axis_extremum_finder_mc: windowed per-channel signed max/min over an AXI-Stream sample path,
// one result beat per window, continuous or armed single-shot.
module axis_extremum_finder_mc
    import axis_extremum_finder_pkg::*;
#(
    parameter int CHANNEL_COUNT   = DEF_CHANNEL_COUNT,
    parameter int CHANNEL_WIDTH   = DEF_CHANNEL_WIDTH,
    parameter int LOG_COUNT_WIDTH = DEF_LOG_COUNT_WIDTH
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [LOG_COUNT_WIDTH-1:0]             EF_log_count,
    input  logic [2:0]                             EF_shift,
    input  logic                                   EF_single,
    input  logic                                   EF_arm,
    input  logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] S_AXIS_tdata,
    input  logic                                   S_AXIS_tvalid,
    output logic [2*CHANNEL_COUNT*CHANNEL_WIDTH-1:0] M_AXIS_tdata,
    output logic                                   M_AXIS_tvalid,
    input  logic                                   M_AXIS_tready,
    output logic                                   EF_overflow
);
    localparam int CNT_W = 2**LOG_COUNT_WIDTH;
    localparam int OUT_W = 2*CHANNEL_COUNT*CHANNEL_WIDTH;
    ef_state_t                  state_q, state_d;
    logic [LOG_COUNT_WIDTH-1:0] win_log_q, win_log_d;
    logic [2:0]                 win_shift_q, win_shift_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [OUT_W-1:0]           tdata_q, tdata_d, res;
    logic                       tvalid_q, tvalid_d, ovf_q, ovf_d;
    logic                       cfg_on, acc_valid, first, win_end, load_cfg;
    assign cfg_on    = EF_log_count != '0;
    assign acc_valid = (state_q == ACCUM) && cfg_on && S_AXIS_tvalid;
    assign first     = cnt_q == '0;
    assign win_end   = acc_valid && ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << win_log_q));
    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
        logic signed [CHANNEL_WIDTH-1:0] mx, mn;
        axis_extremum_channel #(.W(CHANNEL_WIDTH)) u_ch (
            .aclk_i  (aclk),
            .areset_i(areset),
            .sample_i(S_AXIS_tdata[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .valid_i (acc_valid),
            .first_i (first),
            .shift_i (win_shift_q),
            .max_o   (mx),
            .min_o   (mn)
        );
        assign res[c*2*CHANNEL_WIDTH +: 2*CHANNEL_WIDTH] = {mx, mn};
    end
    always_comb begin
        state_d     = state_q;
        win_log_d   = win_log_q;
        win_shift_d = win_shift_q;
        cnt_d       = cnt_q;
        load_cfg    = 1'b0;
        tvalid_d    = tvalid_q && !M_AXIS_tready;
        tdata_d     = tdata_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                load_cfg = cfg_on && (!EF_single || EF_arm);
                state_d  = load_cfg ? ACCUM : IDLE;
            end
            ACCUM: begin
                if (!cfg_on) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (acc_valid) begin
                    cnt_d    = win_end ? '0 : cnt_q + CNT_W'(1);
                    load_cfg = win_end && !EF_single;
                    state_d  = (win_end && EF_single) ? DONE : ACCUM;
                end
            end
            DONE: begin
                // An arm seen here starts the next single-shot window directly.
                load_cfg = EF_arm && cfg_on;
                state_d  = load_cfg ? ACCUM : ((EF_arm || !EF_single) ? IDLE : DONE);
            end
            default: state_d = IDLE;
        endcase
        if (load_cfg) begin
            win_log_d   = EF_log_count;
            win_shift_d = EF_shift;
            cnt_d       = '0;
        end
        if (win_end) begin
            if (tvalid_q && !M_AXIS_tready) begin
                ovf_d = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = res;
            end
        end
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            win_log_q   <= '0;
            win_shift_q <= '0;
            cnt_q       <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_log_q   <= win_log_d;
            win_shift_q <= win_shift_d;
            cnt_q       <= cnt_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            ovf_q       <= ovf_d;
        end
    end
    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign EF_overflow   = ovf_q;
endmodule

// File: tb/tb_axis_extremum_finder_mc.sv
// tb_axis_extremum_finder_mc: directed stimulus with a result scoreboard drained by a monitor.
module tb_axis_extremum_finder_mc;
    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  log_count;
    logic [2:0]  shift;
    logic        single, arm;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tready, overflow;
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    axis_extremum_finder_mc dut (
        .aclk         (clk),
        .areset       (areset),
        .EF_log_count (log_count),
        .EF_shift     (shift),
        .EF_single    (single),
        .EF_arm       (arm),
        .S_AXIS_tdata (s_tdata),
        .S_AXIS_tvalid(s_tvalid),
        .M_AXIS_tdata (m_tdata),
        .M_AXIS_tvalid(m_tvalid),
        .M_AXIS_tready(m_tready),
        .EF_overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int amx, input int amn, input int bmx, input int bmn);
        return {16'(bmx), 16'(bmn), 16'(amx), 16'(amn)};
    endfunction

    always @(negedge clk) begin
        if (!areset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", m_tdata);
            end else begin
                chk("beat_data", m_tdata, exp_q.pop_front());
            end
        end
    end

    task automatic beat(input logic v, input int a, input int b);
        s_tvalid = v;
        s_tdata  = {16'(b), 16'(a)};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 999, -999);
    endtask

    task automatic cfg(input logic [4:0] lc, input logic [2:0] sh, input logic sg);
        log_count = '0;
        idle(2);
        shift  = sh;
        single = sg;
        idle(1);
        log_count = lc;
        idle(2);
    endtask

    int t1[8] = '{-10, -30, -40, -20, 10, 20, 30, 40};

    initial begin
        areset = 1'b1; log_count = '0; shift = '0; single = 1'b0; arm = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("reset_tdata", m_tdata, 64'd0);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);
        areset = 1'b0;
        // 1: basic window of 8 on channel 0
        cfg(5'd3, 3'd0, 1'b0);
        exp_q.push_back(pk(40, -40, 0, 0));
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, t1[i], 0);
            if (i == 6) chk("t1_tvalid_before_last", {63'd0, m_tvalid}, 64'd0);
        end
        chk("t1_tvalid_after_last", {63'd0, m_tvalid}, 64'd1);
        idle(2);
        // 2: shift by one, channel 1 negated, bit-exact packing
        cfg(5'd3, 3'd1, 1'b0);
        exp_q.push_back(64'h0014_FFEC_0014_FFEC);
        for (int i = 0; i < 8; i++) beat(1'b1, t1[i], -t1[i]);
        idle(2);
        // 3: gaps in tvalid are ignored
        cfg(5'd2, 3'd0, 1'b0);
        exp_q.push_back(pk(7, -1, 1, 1));
        beat(1'b1, 3, 1); beat(1'b0, 1000, -1000);
        beat(1'b1, 7, 1); beat(1'b0, -1000, 1000);
        beat(1'b1, -1, 1); beat(1'b0, 1000, 1000);
        chk("t3_tvalid_before_4th", {63'd0, m_tvalid}, 64'd0);
        beat(1'b1, 2, 1);
        chk("t3_tvalid_after_4th", {63'd0, m_tvalid}, 64'd1);
        idle(2);
        // 4a: window ends in the same cycle the pending beat is accepted
        m_tready = 1'b0;
        exp_q.push_back(pk(4, 1, 0, 0));
        exp_q.push_back(pk(-5, -8, 0, 0));
        for (int i = 1; i <= 4; i++) beat(1'b1, i, 0);
        beat(1'b1, -5, 0); beat(1'b1, -6, 0); beat(1'b1, -7, 0);
        m_tready = 1'b1;
        beat(1'b1, -8, 0);
        chk("t4_tvalid_stays", {63'd0, m_tvalid}, 64'd1);
        idle(2);
        chk("t4_no_overflow", {63'd0, overflow}, 64'd0);
        // 4b: second window ends while the first result is still pending
        m_tready = 1'b0;
        exp_q.push_back(pk(4, 1, 0, 0));
        for (int i = 1; i <= 4; i++) beat(1'b1, i, 0);
        chk("t4_pending_data", m_tdata, pk(4, 1, 0, 0));
        for (int i = 0; i < 4; i++) beat(1'b1, 9, 9);
        chk("t4_held_data", m_tdata, pk(4, 1, 0, 0));
        chk("t4_overflow", {63'd0, overflow}, 64'd1);
        m_tready = 1'b1;
        idle(2);
        chk("t4_overflow_sticky", {63'd0, overflow}, 64'd1);
        // 5: single-shot, one beat per arm
        cfg(5'd2, 3'd0, 1'b1);
        arm = 1'b1; idle(1); arm = 1'b0;
        exp_q.push_back(pk(8, 5, 0, 0));
        for (int i = 5; i <= 8; i++) beat(1'b1, i, 0);
        for (int i = 0; i < 4; i++) beat(1'b1, 50 + i, 3);
        idle(2);
        chk("t5_no_extra_beat", {63'd0, m_tvalid}, 64'd0);
        arm = 1'b1; idle(1); arm = 1'b0;
        exp_q.push_back(pk(-1, -4, 0, 0));
        for (int i = 1; i <= 4; i++) beat(1'b1, -i, 0);
        for (int i = 0; i < 4; i++) beat(1'b1, 60, 60);
        idle(2);
        // 6: reset mid-window, then abort via log_count=0, then a fresh window
        cfg(5'd2, 3'd0, 1'b0);
        beat(1'b1, 100, 100); beat(1'b1, 200, 200);
        #1 areset = 1'b1;
        #1;
        chk("t6_reset_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("t6_reset_tdata", m_tdata, 64'd0);
        chk("t6_reset_overflow", {63'd0, overflow}, 64'd0);
        #1 areset = 1'b0;
        idle(3);
        for (int i = 0; i < 3; i++) beat(1'b1, 77, 77);
        log_count = '0;
        idle(3);
        chk("t6_abort_no_beat", {63'd0, m_tvalid}, 64'd0);
        log_count = 5'd2;
        idle(2);
        exp_q.push_back(pk(5, 5, 5, 5));
        for (int i = 0; i < 4; i++) beat(1'b1, 5, 5);
        log_count = '0;
        idle(4);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
